// File: rtl/pio_mouse_event_rx.sv
// Receives the HPS mouse PIO bundle, waits for it to settle, and queues
// click/drag events for the lattice logic in a small first-word-fallthrough FIFO.
module pio_mouse_event_rx #(
    parameter int COORD_W    = 27,
    parameter int GRID_X     = 320,
    parameter int GRID_Y     = 240,
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int STABLE_CYC = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [COORD_W-1:0]            pio_x_coord,
    input  logic [COORD_W-1:0]            pio_y_coord,
    input  logic [31:0]                   pio_left_click,
    input  logic [31:0]                   pio_right_click,
    input  logic [31:0]                   pio_direction,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [1:0]                    evt_type,
    output logic [X_W-1:0]                evt_x,
    output logic [Y_W-1:0]                evt_y,
    output logic [3:0]                    evt_dir,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_cnt
);

    localparam int E_W = 2 + X_W + Y_W + 4;
    localparam int P_W = $clog2(FIFO_DEPTH);
    localparam int C_W = $clog2(STABLE_CYC + 1);

    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_X - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_Y - 1);
    localparam logic [C_W-1:0]     CNT_MAX  = C_W'(STABLE_CYC);
    localparam logic [C_W-1:0]     CNT_PRE  = C_W'(STABLE_CYC - 1);
    localparam logic [P_W:0]       LVL_FULL = (P_W + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               r;
        logic               l;
        logic [3:0]         dir;
    } bundle_t;

    function automatic logic [X_W-1:0] clamp_x(input logic [COORD_W-1:0] v);
        logic [COORD_W-1:0] c;
        c = (v > X_MAX) ? X_MAX : v;
        return c[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] clamp_y(input logic [COORD_W-1:0] v);
        logic [COORD_W-1:0] c;
        c = (v > Y_MAX) ? Y_MAX : v;
        return c[Y_W-1:0];
    endfunction

    function automatic logic [3:0] fix_dir(input logic [3:0] d);
        return (d > 4'd8) ? 4'd0 : d;
    endfunction

    bundle_t             raw;
    bundle_t             sync_p0, sync_p1, prev_p2, committed;
    logic [C_W-1:0]      cnt_p2;
    logic                settle_p2;
    logic                same;
    logic                push, pop, wr_en, full, drop;
    logic [E_W-1:0]      evt_in, head;
    logic [E_W-1:0]      mem [FIFO_DEPTH];
    logic [P_W-1:0]      wr_ptr, rd_ptr;
    logic [P_W:0]        level;
    logic                unused_bits;

    assign unused_bits = ^{pio_left_click[31:1], pio_right_click[31:1], pio_direction[31:4]};

    always_comb begin
        raw     = '0;
        raw.x   = pio_x_coord;
        raw.y   = pio_y_coord;
        raw.r   = pio_right_click[0];
        raw.l   = pio_left_click[0];
        raw.dir = pio_direction[3:0];
    end

    assign same = (sync_p1 == prev_p2);

    // Stage p0/p1: per-bit synchroniser; p2: stability filter over the whole bundle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            prev_p2   <= '0;
            cnt_p2    <= '0;
            settle_p2 <= 1'b0;
        end else begin
            sync_p0   <= raw;
            sync_p1   <= sync_p0;
            prev_p2   <= sync_p1;
            if (!same)
                cnt_p2 <= '0;
            else if (cnt_p2 != CNT_MAX)
                cnt_p2 <= cnt_p2 + C_W'(1);
            settle_p2 <= same && (cnt_p2 == CNT_PRE);
        end
    end

    // Commit stage: releases and idle moves only update the committed copy
    assign push   = settle_p2 && (prev_p2 != committed) && (prev_p2.l | prev_p2.r);
    assign evt_in = {prev_p2.r, prev_p2.l, clamp_x(prev_p2.x), clamp_y(prev_p2.y),
                     fix_dir(prev_p2.dir)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            committed <= '0;
        else if (settle_p2)
            committed <= prev_p2;
    end

    // Event FIFO
    assign evt_valid = (level != '0);
    assign full      = (level == LVL_FULL);
    assign pop       = evt_valid && evt_ready;
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= evt_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + P_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + P_W'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + (P_W + 1)'(1);
                2'b01:   level <= level - (P_W + 1)'(1);
                default: level <= level;
            endcase
            if (drop && (overflow_cnt != 16'hFFFF))
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

    assign head       = mem[rd_ptr];
    assign fifo_level = level;

    always_comb begin
        {evt_type, evt_x, evt_y, evt_dir} = '0;
        if (evt_valid)
            {evt_type, evt_x, evt_y, evt_dir} = head;
    end

endmodule

// File: tb/tb_pio_mouse_event_rx.sv
// Scoreboard bench for pio_mouse_event_rx: a high-level click model predicts
// events at stimulus time, a monitor compares them as the FIFO hands them out.
module tb_pio_mouse_event_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [26:0] pio_x_coord, pio_y_coord;
    logic [31:0] pio_left_click, pio_right_click, pio_direction;
    logic        evt_valid, evt_ready;
    logic [1:0]  evt_type;
    logic [8:0]  evt_x;
    logic [7:0]  evt_y;
    logic [3:0]  evt_dir;
    logic [2:0]  fifo_level;
    logic [15:0] overflow_cnt;

    pio_mouse_event_rx dut (
        .clk(clk), .reset_n(reset_n),
        .pio_x_coord(pio_x_coord), .pio_y_coord(pio_y_coord),
        .pio_left_click(pio_left_click), .pio_right_click(pio_right_click),
        .pio_direction(pio_direction),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_type(evt_type), .evt_x(evt_x), .evt_y(evt_y), .evt_dir(evt_dir),
        .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int x; int y; int d; } ev_t;
    ev_t exp_q[$];

    int checks = 0, errors = 0;
    int exp_ovf = 0;
    int cx = 0, cy = 0, cl = 0, cr = 0, cd = 0;
    bit rand_mode = 1'b0;
    bit ready_cmd = 1'b0;

    always @(posedge clk) begin
        #2;
        evt_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int x, input int y, input int l, input int r, input int dir);
        logic [31:0] rl, rr, rd, dv;
        rl = $urandom(); rr = $urandom(); rd = $urandom(); dv = dir;
        pio_x_coord     = 27'(x);
        pio_y_coord     = 27'(y);
        pio_left_click  = {rl[31:1], l[0]};
        pio_right_click = {rr[31:1], r[0]};
        pio_direction   = {rd[31:4], dv[3:0]};
    endtask

    // Reference: an event is a settled change of bundle while a button is held
    task automatic issue(input int x, input int y, input int l, input int r, input int dir,
                         input bit pop_same);
        ev_t e;
        int  d4;
        d4 = dir % 16;
        drive(x, y, l, r, dir);
        if ((x != cx || y != cy || l != cl || r != cr || d4 != cd) && (l != 0 || r != 0)) begin
            e.t = r * 2 + l;
            e.x = (x > 319) ? 319 : x;
            e.y = (y > 239) ? 239 : y;
            e.d = (d4 > 8) ? 0 : d4;
            if (exp_q.size() >= 4 && !pop_same) begin
                if (exp_ovf < 65535) exp_ovf++;
            end else begin
                exp_q.push_back(e);
            end
        end
        cx = x; cy = y; cl = l; cr = r; cd = d4;
    endtask

    task automatic monitor_loop();
        ev_t e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL evt_unexpected got type=%0d x=%0d y=%0d dir=%0d want none",
                             evt_type, evt_x, evt_y, evt_dir);
                end else begin
                    e = exp_q.pop_front();
                    if (evt_type != e.t || evt_x != e.x || evt_y != e.y || evt_dir != e.d) begin
                        errors++;
                        $display("FAIL evt_data got type=%0d x=%0d y=%0d dir=%0d want type=%0d x=%0d y=%0d dir=%0d",
                                 evt_type, evt_x, evt_y, evt_dir, e.t, e.x, e.y, e.d);
                    end
                end
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        ready_cmd = 1'b1;
        while ((exp_q.size() != 0 || evt_valid === 1'b1) && n < 300) begin
            tick(1);
            n++;
        end
        chk({name, "_drain_timeout"}, (n < 300) ? 1 : 0, 1);
        chk({name, "_empty"}, evt_valid, 0);
        ready_cmd = 1'b0;
        tick(1);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_valid"}, evt_valid, 0);
        chk({name, "_level"}, fifo_level, 0);
        chk({name, "_ovf"}, overflow_cnt, 0);
        chk({name, "_fields"}, {evt_type, evt_x, evt_y, evt_dir}, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        fork monitor_loop(); join_none
        #1;
        check_zero("reset");
        tick(3);
        @(negedge clk);
        reset_n = 1'b1;
        tick(12);
        chk("idle_level", fifo_level, 0);

        // First click: latency and no repeat while held
        issue(100, 50, 1, 0, 3, 0);
        tick(7);
        chk("lat_early", evt_valid, 0);
        tick(1);
        chk("lat_edge8", evt_valid, 1);
        chk("first_x", evt_x, 100);
        chk("first_type", evt_type, 1);
        tick(20);
        chk("no_repeat", fifo_level, 1);
        drain("t1");

        // Short glitch must not produce an event; a held move must
        drive(101, 50, 1, 0, 3);
        tick(2);
        issue(100, 50, 1, 0, 3, 0);
        tick(20);
        chk("glitch_level", fifo_level, 0);
        issue(101, 50, 1, 0, 3, 0);
        tick(14);
        chk("move_level", fifo_level, 1);
        drain("t2");

        // Clamping and direction sanitising
        issue(5000, 240, 0, 1, 12, 0);
        tick(14);
        chk("clamp_x", evt_x, 319);
        chk("clamp_y", evt_y, 239);
        chk("clamp_dir", evt_dir, 0);
        drain("t3");

        // Overflow: six events with no consumer
        for (int i = 0; i < 6; i++) begin
            issue(10 + i, 20 + i, 1, i % 2, i, 0);
            tick(14);
        end
        chk("ovf_level", fifo_level, 4);
        chk("ovf_cnt", overflow_cnt, exp_ovf);
        chk("ovf_cnt_abs", overflow_cnt, 2);
        drain("t4");

        // Push and pop together while full
        for (int i = 0; i < 4; i++) begin
            issue(200 + i, 100, 0, 1, 8 - i, 0);
            tick(14);
        end
        chk("full_level", fifo_level, 4);
        issue(250, 120, 1, 1, 5, 1);
        tick(7);
        ready_cmd = 1'b1;
        tick(1);
        ready_cmd = 1'b0;
        tick(1);
        chk("pushpop_level", fifo_level, 4);
        chk("pushpop_ovf", overflow_cnt, 2);
        drain("t5");

        // Asynchronous reset with queued events and a filter mid-count
        issue(30, 31, 1, 0, 1, 0); tick(14);
        issue(32, 33, 0, 1, 2, 0); tick(14);
        drive(40, 41, 1, 0, 4);
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        exp_q.delete();
        exp_ovf = 0;
        cx = 0; cy = 0; cl = 0; cr = 0; cd = 0;
        issue(7, 9, 1, 0, 8, 0);
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        tick(7);
        chk("rst_lat_early", evt_valid, 0);
        tick(1);
        chk("rst_lat_edge8", evt_valid, 1);
        tick(20);
        chk("rst_one_event", fifo_level, 1);
        drain("t6");

        // Randomised traffic with a randomly stalling consumer
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int k, x, y, l, r, d;
            k = $urandom_range(0, 4);
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 27'h7FF_FFFF)) : int'($urandom_range(0, 400));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 27'h7FF_FFFF)) : int'($urandom_range(0, 300));
            l = $urandom_range(0, 1);
            r = $urandom_range(0, 1);
            d = $urandom_range(0, 15);
            case (k)
                0: issue(x, y, l, r, d, 0);
                1: begin
                    drive(x ^ 1, y, 1, 0, d);
                    tick($urandom_range(1, 2));
                    issue(x, y, l, r, d, 0);
                end
                2: issue(cx, cy, 0, 0, cd, 0);
                3: issue(cx + 1, cy, 1, cr, cd, 0);
                default: issue(cx, cy, cl, cr, cd, 0);
            endcase
            tick(14);
        end
        rand_mode = 1'b0;
        tick(2);
        drain("rand");
        chk("final_ovf", overflow_cnt, exp_ovf);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_mouse_event_rx.md
Name: pio_mouse_event_rx

Overview:
- FPGA-side reader for the mouse PIO bundle the HPS writes: x_coord, y_coord, left_click, right_click and direction.
- Resynchronises the bundle into the fabric clock and waits until all fields have settled, since the HPS writes the PIOs one register at a time.
- Turns each settled click, or each coordinate change while a button is held, into a valid/ready event for the lattice obstacle/injection logic.
- Buffers events in a small FIFO and counts drops.

Parameters:
- COORD_W, 27, width of the x/y PIO exports
- GRID_X, 320, lattice width; x is clamped to GRID_X-1
- GRID_Y, 240, lattice height; y is clamped to GRID_Y-1
- X_W, 9, output x width (must satisfy 2^X_W >= GRID_X)
- Y_W, 8, output y width (must satisfy 2^Y_W >= GRID_Y)
- STABLE_CYC, 4, consecutive equal samples required before the bundle counts as settled (>=1)
- FIFO_DEPTH, 4, event FIFO entries (power of 2)

Ports:
- clk  in  1  fabric clock
- reset_n  in  1  asynchronous active-low reset
- pio_x_coord  in  COORD_W  HPS x coordinate, asynchronous to clk
- pio_y_coord  in  COORD_W  HPS y coordinate, asynchronous to clk
- pio_left_click  in  32  bit0 = left button held; other bits ignored
- pio_right_click  in  32  bit0 = right button held; other bits ignored
- pio_direction  in  32  bits[3:0] = D2Q9 direction 0..8
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head event
- evt_type  out  2  01 left, 10 right, 11 both
- evt_x  out  X_W  clamped x
- evt_y  out  Y_W  clamped y
- evt_dir  out  4  direction, forced to 0 if >8
- fifo_level  out  log2(FIFO_DEPTH)+1  occupancy
- overflow_cnt  out  16  dropped events, saturating

Behaviour:
- Reset (async, reset_n=0): sync flops, sample register, stability counter, committed bundle, FIFO pointers and overflow_cnt all go to 0 immediately. Outputs read 0: evt_valid=0, evt_type/evt_x/evt_y/evt_dir=0, fifo_level=0.
- Synchronisation: the bundle is x[COORD_W], y[COORD_W], L, R and dir[3:0]. Every bit passes through a 2-flop synchroniser; multi-bit coherence comes from the stability filter only.
- Stability filter:
  - prev register holds the last synchronised bundle.
  - If sync==prev, cnt increments, saturating at STABLE_CYC; otherwise cnt=0.
  - settle is a one-cycle pulse when cnt transitions to STABLE_CYC.
- Commit stage, on the cycle after settle:
  - If the settled bundle differs from the committed bundle and (L|R)=1, push an event.
  - The committed bundle is updated to the settled bundle in either case, so button releases and idle coordinate moves update state without producing events.
  - Committed bundle resets to all-zero, so a click already held at reset exit produces exactly one event.
- Event fields:
  - type = {R,L}.
  - x = min(x_in, GRID_X-1), y = min(y_in, GRID_Y-1), compared at full COORD_W width, then truncated to X_W/Y_W.
  - dir = dir_in if ≤8, else 0.
- Latency: evt_valid rises exactly STABLE_CYC+4 clk edges after the edge at which a stable new bundle is first presented, given an empty FIFO (8 edges with the default STABLE_CYC=4). A change arriving before settle restarts the count.
- FIFO:
  - First-word-fallthrough: evt_* reflect the head whenever evt_valid=1, and stay stable while evt_valid=1 and evt_ready=0.
  - Pop when evt_valid & evt_ready.
  - Push when full and no pop in the same cycle: drop the event, overflow_cnt+1, saturating at 0xFFFF.
  - Push and pop in the same cycle when full: no drop; level unchanged.
  - Push and pop in the same cycle when empty: the pushed event is not popped (head appears next cycle).
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is the exact occupancy.
- evt_ready while empty has no effect.

Test Plan:
- Reset, then x=100, y=50, L=1, dir=3 applied together and held → evt_valid at edge 8: type=01, x=100, y=50, dir=3. Holding further produces no second event.
- With L held, x toggles 100→101 for only 2 cycles then back to 100 → no event. x moves to 101 and is held → one event with x=101.
- x=5000, y=240, R=1, dir=12 → type=10, x=319, y=239, dir=0.
- evt_ready=0, 6 distinct click events → fifo_level=4, overflow_cnt=2. Drain with ready=1 → the first 4 events in order, then evt_valid=0.
- FIFO full with ready=1 on the same cycle as a new push → level stays 4, overflow_cnt unchanged.
- Assert reset_n=0 while 2 events are queued and the filter is mid-count → all outputs 0 asynchronously. After release with L=1 held → exactly one event after STABLE_CYC+4 edges.
